// File: rtl/offset_mem_be.sv
`default_nettype none
// ============================================================================
//  Module      : offset_mem_be
//  Description : Multi-read-port memory mapped onto an address window
//                [OFFSET, OFFSET+DEPTH) with byte-lane write strobes,
//                combinational or registered reads, a read-during-write
//                policy for registered reads, and a post-reset zero-fill.
//  Revision    : 1.0  initial release
// ============================================================================
module offset_mem_be #(
    parameter int WIDTH    = 80,
    parameter int DEPTH    = 32,
    parameter int OFFSET   = 32,
    parameter int AW       = 6,
    parameter int LANE     = 8,
    parameter int SYNCREAD = 0,
    parameter int NRPORT   = 1,
    parameter int RDW      = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     busy,
    input  logic [NRPORT-1:0]        ren,
    input  logic [NRPORT*AW-1:0]     raddr,
    output logic [NRPORT*WIDTH-1:0]  rdata,
    output logic [NRPORT-1:0]        rerr,
    input  logic                     wen,
    input  logic [AW-1:0]            waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [WIDTH/LANE-1:0]    wstrb,
    output logic                     werr
);

    localparam int              c_NL   = WIDTH / LANE;
    localparam int              c_IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Window bounds carry one extra bit so OFFSET+DEPTH == 2^AW does not wrap
    localparam logic [AW:0]     c_LO   = (AW+1)'(OFFSET);
    localparam logic [AW:0]     c_HI   = (AW+1)'(OFFSET + DEPTH);
    localparam logic [c_IW-1:0] c_LAST = c_IW'(DEPTH - 1);

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    state_t            r_state;
    logic [c_IW-1:0]   r_cnt;
    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic              r_werr;

    logic              w_whit;
    logic [c_IW-1:0]   w_widx;
    logic              w_wr_go;

    function automatic logic f_hit(input logic [AW-1:0] a);
        return ({1'b0, a} >= c_LO) && ({1'b0, a} < c_HI);
    endfunction

    function automatic logic [c_IW-1:0] f_idx(input logic [AW-1:0] a);
        return c_IW'({1'b0, a} - c_LO);
    endfunction

    assign busy    = (r_state == CLEAR);
    assign w_whit  = f_hit(waddr);
    assign w_widx  = f_idx(waddr);
    // Writes are only accepted once the fill has completed
    assign w_wr_go = wen && w_whit && !busy && !rst;
    assign werr    = r_werr;

    // Sequencer: reset restarts the zero-fill, which walks every entry once
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= CLEAR;
            r_cnt   <= '0;
        end else if (r_state == CLEAR) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == c_LAST) begin
                r_state <= IDLE;
            end
        end
    end

    // Storage: zero-fill while clearing, otherwise lane-masked writes
    always_ff @(posedge clk) begin
        if (!rst && busy) begin
            r_mem[r_cnt] <= '0;
        end else if (w_wr_go) begin
            for (int l = 0; l < c_NL; l++) begin
                if (wstrb[l]) begin
                    r_mem[w_widx][l*LANE +: LANE] <= wdata[l*LANE +: LANE];
                end
            end
        end
    end

    // Out-of-window write flag, one cycle after the offending request
    always_ff @(posedge clk) begin
        if (rst) begin
            r_werr <= 1'b0;
        end else begin
            r_werr <= wen && !w_whit && !busy;
        end
    end

    if (SYNCREAD == 0) begin : g_ren_unused
        // Read enables have no effect on combinational reads
        logic w_unused_ren;
        assign w_unused_ren = ^ren;
    end

    for (genvar p = 0; p < NRPORT; p++) begin : g_port
        logic [AW-1:0]    w_ra;
        logic             w_rhit;
        logic [c_IW-1:0]  w_ridx;
        logic [WIDTH-1:0] w_rword;

        assign w_ra    = raddr[p*AW +: AW];
        assign w_rhit  = f_hit(w_ra);
        assign w_ridx  = f_idx(w_ra);
        assign w_rword = r_mem[w_ridx];

        if (SYNCREAD != 0) begin : g_sync
            logic [WIDTH-1:0] w_load;
            logic [WIDTH-1:0] r_data;
            logic             r_err;

            // Load word; with write-through, strobed lanes of a colliding write bypass the array
            always_comb begin
                w_load = w_rword;
                if ((RDW != 0) && w_wr_go && (w_widx == w_ridx)) begin
                    for (int l = 0; l < c_NL; l++) begin
                        if (wstrb[l]) begin
                            w_load[l*LANE +: LANE] = wdata[l*LANE +: LANE];
                        end
                    end
                end
            end

            // Read registers load on an enabled read once idle and hold otherwise
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_data <= '0;
                    r_err  <= 1'b0;
                end else if (ren[p] && !busy) begin
                    r_data <= w_rhit ? w_load : '0;
                    r_err  <= !w_rhit;
                end
            end

            assign rdata[p*WIDTH +: WIDTH] = r_data;
            assign rerr[p]                 = r_err;
        end else begin : g_async
            assign rdata[p*WIDTH +: WIDTH] = (!busy && w_rhit) ? w_rword : '0;
            assign rerr[p]                 = !busy && !w_rhit;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_offset_mem_be.sv
`default_nettype none
// ============================================================================
//  Module      : tb_offset_mem_be
//  Description : Scoreboard bench for offset_mem_be. Three instances share
//                stimulus: async read, sync read with old-data collisions,
//                and sync read with write-through collisions.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_offset_mem_be;

    localparam int W   = 80;
    localparam int DEP = 32;
    localparam int OFF = 32;
    localparam int AW  = 6;
    localparam int NL  = 10;
    localparam int NP  = 2;

    logic              clk;
    logic              rst;
    logic              wen;
    logic [AW-1:0]     waddr;
    logic [W-1:0]      wdata;
    logic [NL-1:0]     wstrb;
    logic [NP-1:0]     ren;
    logic [NP*AW-1:0]  raddr;

    logic              busy_a, busy_b, busy_c;
    logic              werr_a, werr_b, werr_c;
    logic [NP*W-1:0]   rdata_a, rdata_b, rdata_c;
    logic [NP-1:0]     rerr_a, rerr_b, rerr_c;

    offset_mem_be #(.WIDTH(W), .DEPTH(DEP), .OFFSET(OFF), .AW(AW), .LANE(8),
                    .SYNCREAD(0), .NRPORT(NP), .RDW(0)) u_a (
        .clk(clk), .rst(rst), .busy(busy_a), .ren(ren), .raddr(raddr),
        .rdata(rdata_a), .rerr(rerr_a), .wen(wen), .waddr(waddr),
        .wdata(wdata), .wstrb(wstrb), .werr(werr_a));

    offset_mem_be #(.WIDTH(W), .DEPTH(DEP), .OFFSET(OFF), .AW(AW), .LANE(8),
                    .SYNCREAD(1), .NRPORT(NP), .RDW(0)) u_b (
        .clk(clk), .rst(rst), .busy(busy_b), .ren(ren), .raddr(raddr),
        .rdata(rdata_b), .rerr(rerr_b), .wen(wen), .waddr(waddr),
        .wdata(wdata), .wstrb(wstrb), .werr(werr_b));

    offset_mem_be #(.WIDTH(W), .DEPTH(DEP), .OFFSET(OFF), .AW(AW), .LANE(8),
                    .SYNCREAD(1), .NRPORT(NP), .RDW(1)) u_c (
        .clk(clk), .rst(rst), .busy(busy_c), .ren(ren), .raddr(raddr),
        .rdata(rdata_c), .rerr(rerr_c), .wen(wen), .waddr(waddr),
        .wdata(wdata), .wstrb(wstrb), .werr(werr_c));

    typedef struct packed {
        logic               busy;
        logic               werr;
        logic [NP-1:0][W-1:0] ad;
        logic [NP-1:0][W-1:0] bd;
        logic [NP-1:0][W-1:0] cd;
        logic [NP-1:0]      ae;
        logic [NP-1:0]      be;
        logic [NP-1:0]      ce;
    } exp_t;

    exp_t sb [$];

    // Reference model state
    logic [W-1:0]          mm [DEP];
    bit                    mbusy;
    int                    mcnt;
    bit                    mwerr;
    logic [NP-1:0][W-1:0]  mbd, mcd;
    logic [NP-1:0]         mbe, mce;

    int n_chk;
    int n_pass;
    int cyc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    function automatic bit f_hit(input logic [AW-1:0] a);
        return (int'(a) >= OFF) && (int'(a) < OFF + DEP);
    endfunction

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    // Drive one cycle, predict the post-edge outputs, then compare them
    task automatic step(input logic r, input logic w, input logic [AW-1:0] wa,
                        input logic [W-1:0] wd, input logic [NL-1:0] ws,
                        input logic [NP-1:0] re, input logic [NP*AW-1:0] ra);
        exp_t          e;
        logic [W-1:0]  old [DEP];
        logic [AW-1:0] a;
        @(negedge clk);
        rst = r; wen = w; waddr = wa; wdata = wd; wstrb = ws; ren = re; raddr = ra;

        old = mm;
        if (r) begin
            mbusy = 1'b1; mcnt = 0; mwerr = 1'b0;
            mbd = '0; mbe = '0; mcd = '0; mce = '0;
        end else if (mbusy) begin
            mm[mcnt] = '0;
            mcnt++;
            if (mcnt == DEP) mbusy = 1'b0;
            mwerr = 1'b0;
        end else begin
            for (int p = 0; p < NP; p++) begin
                if (re[p]) begin
                    a = ra[p*AW +: AW];
                    if (f_hit(a)) begin
                        mbd[p] = old[int'(a) - OFF];
                        mcd[p] = old[int'(a) - OFF];
                        if (w && f_hit(wa) && (wa == a)) begin
                            for (int l = 0; l < NL; l++)
                                if (ws[l]) mcd[p][l*8 +: 8] = wd[l*8 +: 8];
                        end
                        mbe[p] = 1'b0; mce[p] = 1'b0;
                    end else begin
                        mbd[p] = '0; mcd[p] = '0; mbe[p] = 1'b1; mce[p] = 1'b1;
                    end
                end
            end
            if (w && f_hit(wa)) begin
                for (int l = 0; l < NL; l++)
                    if (ws[l]) mm[int'(wa) - OFF][l*8 +: 8] = wd[l*8 +: 8];
            end
            mwerr = w && !f_hit(wa);
        end

        e.busy = mbusy;
        e.werr = mwerr;
        e.bd = mbd; e.be = mbe; e.cd = mcd; e.ce = mce;
        for (int p = 0; p < NP; p++) begin
            a = ra[p*AW +: AW];
            if (mbusy) begin
                e.ad[p] = '0; e.ae[p] = 1'b0;
            end else if (f_hit(a)) begin
                e.ad[p] = mm[int'(a) - OFF]; e.ae[p] = 1'b0;
            end else begin
                e.ad[p] = '0; e.ae[p] = 1'b1;
            end
        end
        sb.push_back(e);

        @(posedge clk);
        #1;
        cyc++;
        e = sb.pop_front();
        check("busy_a", W'(busy_a), W'(e.busy));
        check("busy_b", W'(busy_b), W'(e.busy));
        check("busy_c", W'(busy_c), W'(e.busy));
        check("werr_a", W'(werr_a), W'(e.werr));
        check("werr_b", W'(werr_b), W'(e.werr));
        check("werr_c", W'(werr_c), W'(e.werr));
        for (int p = 0; p < NP; p++) begin
            check($sformatf("a.rdata%0d", p), rdata_a[p*W +: W], e.ad[p]);
            check($sformatf("a.rerr%0d", p),  W'(rerr_a[p]),     W'(e.ae[p]));
            check($sformatf("b.rdata%0d", p), rdata_b[p*W +: W], e.bd[p]);
            check($sformatf("b.rerr%0d", p),  W'(rerr_b[p]),     W'(e.be[p]));
            check($sformatf("c.rdata%0d", p), rdata_c[p*W +: W], e.cd[p]);
            check($sformatf("c.rerr%0d", p),  W'(rerr_c[p]),     W'(e.ce[p]));
        end
    endtask

    task automatic rand_step(input logic r);
        logic [AW-1:0] wa;
        logic [AW-1:0] r0;
        wa = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(28, 63));
        r0 = ($urandom_range(0, 1) == 1) ? wa : AW'($urandom_range(24, 63));
        step(r, 1'($urandom_range(0, 1)), wa, {$urandom, $urandom, 16'($urandom)},
             NL'($urandom), NP'($urandom), {AW'($urandom_range(0, 63)), r0});
    endtask

    logic [W-1:0] pat_a, pat_b;

    initial begin
        n_chk = 0; n_pass = 0; cyc = 0;
        rst = 1'b1; wen = 1'b0; waddr = '0; wdata = '0; wstrb = '0; ren = '0; raddr = '0;
        mbusy = 1'b1; mcnt = 0; mwerr = 1'b0;
        mbd = '0; mbe = '0; mcd = '0; mce = '0;
        for (int i = 0; i < DEP; i++) mm[i] = '0;
        pat_a = {5{16'h1357}};
        pat_b = {5{16'hBEEF}};

        // Reset, then the fill with writes and reads that must be ignored
        step(1'b1, 1'b0, 6'd0, '0, '0, 2'b11, {6'd40, 6'd33});
        step(1'b1, 1'b1, 6'd40, '1, '1, 2'b11, {6'd40, 6'd33});
        for (int i = 0; i < DEP; i++)
            step(1'b0, 1'b1, 6'd40, '1, '1, 2'b11, {6'(63 - i), 6'(32 + i)});

        // Window sweep after fill: hits read zero, low addresses miss
        for (int i = 0; i < DEP; i++)
            step(1'b0, 1'b0, 6'd0, '0, '0, 2'b11, {6'(i), 6'(32 + i)});

        // Lane-masked overwrite of address 40
        step(1'b0, 1'b1, 6'd40, '1, 10'h3FF, 2'b11, {6'd5, 6'd40});
        step(1'b0, 1'b1, 6'd40, '0, 10'h001, 2'b11, {6'd5, 6'd40});
        step(1'b0, 1'b0, 6'd0, '0, '0, 2'b11, {6'd5, 6'd40});

        // Out-of-window writes at both window edges, plus edge-entry writes
        step(1'b0, 1'b1, 6'd31, pat_b, '1, 2'b00, {6'd63, 6'd32});
        step(1'b0, 1'b1, 6'd0, pat_b, '1, 2'b00, {6'd63, 6'd32});
        step(1'b0, 1'b0, 6'd0, '0, '0, 2'b11, {6'd63, 6'd5});
        step(1'b0, 1'b1, 6'd32, pat_a, '1, 2'b11, {6'd63, 6'd32});
        step(1'b0, 1'b1, 6'd63, pat_b, 10'h2AA, 2'b11, {6'd63, 6'd32});
        step(1'b0, 1'b0, 6'd0, '0, '0, 2'b11, {6'd63, 6'd32});

        // Read-during-write on entry 33, full strobes then partial strobes
        step(1'b0, 1'b1, 6'd33, pat_a, '1, 2'b00, {6'd10, 6'd33});
        step(1'b0, 1'b1, 6'd33, pat_b, '1, 2'b01, {6'd10, 6'd33});
        step(1'b0, 1'b0, 6'd0, '0, '0, 2'b01, {6'd10, 6'd33});
        step(1'b0, 1'b1, 6'd33, pat_a, '1, 2'b00, {6'd10, 6'd33});
        step(1'b0, 1'b1, 6'd33, pat_b, 10'h00F, 2'b11, {6'd33, 6'd33});
        step(1'b0, 1'b0, 6'd0, '0, '0, 2'b00, {6'd34, 6'd40});
        step(1'b0, 1'b1, 6'd33, '0, '1, 2'b00, {6'd10, 6'd33});
        step(1'b0, 1'b0, 6'd0, '0, '0, 2'b00, {6'd1, 6'd2});

        // Two ports: one hit, one miss
        step(1'b0, 1'b1, 6'd34, pat_a, '1, 2'b00, {6'd10, 6'd34});
        step(1'b0, 1'b0, 6'd0, '0, '0, 2'b11, {6'd10, 6'd34});

        // Random traffic with a reset mid-operation and another mid-fill
        for (int i = 0; i < 60; i++) rand_step(1'b0);
        rand_step(1'b1);
        for (int i = 0; i < 10; i++) rand_step(1'b0);
        rand_step(1'b1);
        for (int i = 0; i < DEP; i++) rand_step(1'b0);

        // Everything reads back as zero after the repeated fill
        for (int i = 0; i < DEP; i++)
            step(1'b0, 1'b0, 6'd0, '0, '0, 2'b11, {6'(63 - i), 6'(32 + i)});
        for (int i = 0; i < 40; i++) rand_step(1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
